ps2_key_decoder: RTL and testbench
==================================

// Module: ps2_key_decoder
// PURPOSE
//  Downstream stage of the PS/2 receiver. Takes the receiver's byte-ready level (done), scan
//  byte (tasta) and parity flag (data_valid), and brings done into the system clock domain.
//  Tracks E0 (extended) and F0 (break) prefixes plus shift/caps state, and maps make codes to
//  ASCII. Pushes one 18-bit key event per accepted byte into a small FIFO, drained with a
//  valid/ready handshake by the consumer (UART/LCD test logic).
// PARAMETERS
//  FIFO_DEPTH   4   event FIFO entries; power of two, 2..16
//  SYNC_STAGES  2   flops in done synchronizer, >=2
// PORTS
//  clock        in   1   system clock, single clock domain
//  reset        in   1   synchronous, active-high
//  done         in   1   receiver byte-ready level; asynchronous, held high while tasta is stable
//  tasta        in   8   scan byte; stable while done=1
//  data_valid   in   1   parity OK from receiver
//  key_valid    out  1   FIFO head valid
//  key_ready    in   1   consumer accepts head when key_valid&key_ready
//  key_ascii    out  8   ASCII of head event, 8'h00 if unmapped
//  key_code     out  8   raw scan code of head event
//  key_ext      out  1   head event was E0-prefixed
//  key_break    out  1   head event was F0-prefixed (release)
//  overflow     out  1   sticky: event dropped because FIFO full
//  err_cnt      out  8   parity-error byte count, saturates at 8'hFF
// BEHAVIOUR
//  Reset: synchronous, active-high; clock and reset named as above, fixed.
//  - All outputs 0 during reset: key_valid, key_ascii, key_code, key_ext, key_break,
//    overflow, err_cnt.
//  - Also cleared: synchronizer, FIFO pointers, prefix FSM (IDLE), shift_l, shift_r, caps.
//  - Reset mid-prefix discards the pending prefix.
//  Capture: done passes through SYNC_STAGES flops, then a rise detector.
//  - byte_stb asserts SYNC_STAGES+1 cycles after done rises; tasta and data_valid sampled that cycle.
//  - data_valid!=1 -> byte discarded, err_cnt+1 (saturating), FSM unchanged.
//  Prefix FSM (on each accepted byte b):
//  - IDLE:
//    - b=E0 -> EXT.
//    - b=F0 -> BRK.
//    - else emit {ext=0,brk=0} -> IDLE.
//  - EXT:
//    - b=F0 -> EXT_BRK.
//    - b=E0 -> EXT.
//    - else emit {ext=1,brk=0} -> IDLE.
//  - BRK: b=E0/F0 -> stay. Else emit {ext=0,brk=1} -> IDLE.
//  - EXT_BRK: b=E0/F0 -> stay. Else emit {ext=1,brk=1} -> IDLE.
//  Modifier state, updated on each emit:
//  - Non-ext 12 -> shift_l = ~brk.
//  - Non-ext 59 -> shift_r = ~brk.
//  - Non-ext 58 make -> caps toggles; break of 58 has no effect.
//  - Modifier events are still emitted.
//  ASCII mapping (combinational, from code + state before this event's update):
//  - Letters: lower case unless shift XOR caps.
//  - Digits/punctuation: shifted glyph if shift_l|shift_r.
//  - Space 29->20, Enter 5A->0D, Backspace 66->08.
//  - Ext codes and unmapped codes -> 00.
//  FIFO:
//  - Write one cycle after byte_stb.
//  - key_valid rises the cycle after the first write.
//  - Head outputs are registered and stable while key_valid&~key_ready.
//  - Full + write with no simultaneous pop: event dropped, overflow<=1 (cleared only by reset).
//  - Full + simultaneous pop and write: both happen, no drop.
//  - Empty: key_valid=0; head fields hold last value.
//  - Pointers wrap mod FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
// STRUCTURE
//  ps2_pkg:
//  - Scan-code constants: SC_EXT=E0, SC_BRK=F0, SC_LSHIFT=12, SC_RSHIFT=59, SC_CAPS=58.
//  - Prefix FSM state localparams.
//  - Event field offsets: {ascii[17:10], code[9:2], ext[1], brk[0]}.
//  Sub-module ps2_scan_to_ascii:
//  - Combinational case table: code, shift, caps -> ascii.
//  - Prefix FSM, synchronizer and FIFO stay in this module.
// TESTING
//  - 1C, data_valid=1, key_ready=1 -> one event, ascii 61, code 1C, ext 0, brk 0.
//  - 12, then 1C -> ascii 41 on second event.
//  - 12, 58, 1C -> ascii 61 (shift XOR caps).
//  - E0, 75 -> one event: code 75, ext 1, ascii 00.
//  - F0, 12 -> one event: brk 1; following 1C yields 61.
//  - 1C with data_valid=0 -> no event, err_cnt=1.
//  - 255 further errors -> err_cnt stays FF.
//  - key_ready=0, 5 bytes 1C,32,21,23,24 -> 4 events held, overflow=1.
//  - Then key_ready=1 -> drains in order 61,62,63,64; 24 lost.
//  - E0 then reset pulse, then 1C -> ext 0, single event.
//  - FIFO full, pop and new byte in the same cycle -> no overflow, count stays 4.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key decoder.
//   - Scan-code constants for the prefix and modifier bytes.
//   - Prefix FSM state encoding.
//   - Key event layout: {ascii[17:10], code[9:2], ext[1], brk[0]}.
package ps2_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } prefix_state_t;

    localparam int EV_W         = 18;
    localparam int EV_ASCII_LSB = 10;
    localparam int EV_CODE_LSB  = 2;
    localparam int EV_EXT_BIT   = 1;
    localparam int EV_BRK_BIT   = 0;

    // Packed so the field order matches the offsets above.
    typedef struct packed {
        logic [7:0] ascii;
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } key_event_t;

endpackage

// File: rtl/ps2_scan_to_ascii.sv
// Combinational scan-code (set 2) to ASCII table.
//   code  in  8  make code (non-extended)
//   shift in  1  either shift key held
//   caps  in  1  caps-lock active
//   ascii out 8  mapped character, 8'h00 when unmapped
module ps2_scan_to_ascii (
    input  logic [7:0] code,
    input  logic       shift,
    input  logic       caps,
    output logic [7:0] ascii
);

    logic [7:0] letter;
    logic [7:0] plain;
    logic [7:0] shifted;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        letter  = 8'h00;
        plain   = 8'h00;
        shifted = 8'h00;
        case (code)
            8'h1C: letter = "a";  8'h32: letter = "b";  8'h21: letter = "c";
            8'h23: letter = "d";  8'h24: letter = "e";  8'h2B: letter = "f";
            8'h34: letter = "g";  8'h33: letter = "h";  8'h43: letter = "i";
            8'h3B: letter = "j";  8'h42: letter = "k";  8'h4B: letter = "l";
            8'h3A: letter = "m";  8'h31: letter = "n";  8'h44: letter = "o";
            8'h4D: letter = "p";  8'h15: letter = "q";  8'h2D: letter = "r";
            8'h1B: letter = "s";  8'h2C: letter = "t";  8'h3C: letter = "u";
            8'h2A: letter = "v";  8'h1D: letter = "w";  8'h22: letter = "x";
            8'h35: letter = "y";  8'h1A: letter = "z";
            8'h45: begin plain = "0";  shifted = ")"; end
            8'h16: begin plain = "1";  shifted = "!"; end
            8'h1E: begin plain = "2";  shifted = "@"; end
            8'h26: begin plain = "3";  shifted = "#"; end
            8'h25: begin plain = "4";  shifted = "$"; end
            8'h2E: begin plain = "5";  shifted = "%"; end
            8'h36: begin plain = "6";  shifted = "^"; end
            8'h3D: begin plain = "7";  shifted = "&"; end
            8'h3E: begin plain = "8";  shifted = "*"; end
            8'h46: begin plain = "9";  shifted = "("; end
            8'h0E: begin plain = 8'h60; shifted = "~"; end
            8'h4E: begin plain = "-";  shifted = "_"; end
            8'h55: begin plain = "=";  shifted = "+"; end
            8'h54: begin plain = "[";  shifted = "{"; end
            8'h5B: begin plain = "]";  shifted = "}"; end
            8'h5D: begin plain = "\\"; shifted = "|"; end
            8'h4C: begin plain = ";";  shifted = ":"; end
            8'h52: begin plain = "'";  shifted = "\""; end
            8'h41: begin plain = ",";  shifted = "<"; end
            8'h49: begin plain = ".";  shifted = ">"; end
            8'h4A: begin plain = "/";  shifted = "?"; end
            8'h29: begin plain = 8'h20; shifted = 8'h20; end
            8'h5A: begin plain = 8'h0D; shifted = 8'h0D; end
            8'h66: begin plain = 8'h08; shifted = 8'h08; end
            default: ;
        endcase

        // Letters obey shift XOR caps; everything else only looks at shift.
        if (letter != 8'h00)
            ascii = (shift ^ caps) ? (letter - 8'h20) : letter;
        else
            ascii = shift ? shifted : plain;
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 key decoder: synchronizes the receiver's byte-ready level, tracks E0/F0
// prefixes and shift/caps state, and queues one key event per accepted byte.
//   clock       in   1  system clock
//   reset       in   1  synchronous, active-high
//   done        in   1  receiver byte-ready level (asynchronous)
//   tasta       in   8  scan byte, stable while done=1
//   data_valid  in   1  receiver parity OK
//   key_valid   out  1  FIFO head valid
//   key_ready   in   1  consumer pops head when key_valid&key_ready
//   key_ascii   out  8  head ASCII (00 if unmapped or extended)
//   key_code    out  8  head raw scan code
//   key_ext     out  1  head was E0-prefixed
//   key_break   out  1  head was F0-prefixed
//   overflow    out  1  sticky: event dropped on full FIFO
//   err_cnt     out  8  saturating parity-error count
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       done,
    input  logic [7:0] tasta,
    input  logic       data_valid,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [7:0] key_ascii,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       overflow,
    output logic [7:0] err_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    // ---------------- done synchronizer and rise detector ----------------
    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_prev;
    logic                   byte_stb;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync      <= '0;
            sync_prev <= 1'b0;
            byte_stb  <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], done};
            sync_prev <= sync[SYNC_STAGES-1];
            byte_stb  <= sync[SYNC_STAGES-1] & ~sync_prev;
        end
    end

    // ---------------- prefix FSM and modifier state ----------------
    prefix_state_t state;
    logic          shift_l, shift_r, caps;
    logic [7:0]    map_ascii;
    logic          cur_ext, cur_brk;
    logic          ev_valid;
    key_event_t    ev;

    ps2_scan_to_ascii u_map (
        .code  (tasta),
        .shift (shift_l | shift_r),
        .caps  (caps),
        .ascii (map_ascii)
    );

    assign cur_ext = (state == ST_EXT) || (state == ST_EXT_BRK);
    assign cur_brk = (state == ST_BRK) || (state == ST_EXT_BRK);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            shift_l  <= 1'b0;
            shift_r  <= 1'b0;
            caps     <= 1'b0;
            ev_valid <= 1'b0;
            ev       <= '0;
            err_cnt  <= 8'h00;
        end else begin
            ev_valid <= 1'b0;
            if (byte_stb) begin
                if (!data_valid) begin
                    if (err_cnt != 8'hFF)
                        err_cnt <= err_cnt + 8'h01;
                end else if (tasta == SC_EXT || tasta == SC_BRK) begin
                    // Once a break prefix is seen, further prefixes are absorbed.
                    case (state)
                        ST_IDLE: state <= (tasta == SC_EXT) ? ST_EXT : ST_BRK;
                        ST_EXT:  state <= (tasta == SC_BRK) ? ST_EXT_BRK : ST_EXT;
                        default: state <= state;
                    endcase
                end else begin
                    ev_valid <= 1'b1;
                    ev.ascii <= cur_ext ? 8'h00 : map_ascii;
                    ev.code  <= tasta;
                    ev.ext   <= cur_ext;
                    ev.brk   <= cur_brk;
                    state    <= ST_IDLE;
                    if (!cur_ext) begin
                        if (tasta == SC_LSHIFT) shift_l <= ~cur_brk;
                        if (tasta == SC_RSHIFT) shift_r <= ~cur_brk;
                        if (tasta == SC_CAPS && !cur_brk) caps <= ~caps;
                    end
                end
            end
        end
    end

    // ---------------- event FIFO ----------------
    key_event_t          mem [FIFO_DEPTH];
    key_event_t          head;
    logic [PW-1:0]       rd_ptr, wr_ptr;
    logic [CW-1:0]       count;
    logic [CW-1:0]       count_after_pop;
    logic                pop, push, full;

    assign full            = (count == CW'(FIFO_DEPTH));
    assign pop             = key_valid & key_ready;
    // A pop frees the slot in the same cycle, so full+pop+write is not a drop.
    assign push            = ev_valid & (~full | pop);
    assign count_after_pop = count - CW'(pop);

    // NOTE: storage has no reset; only pointers/count define which entries are live.
    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= ev;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            key_valid <= 1'b0;
            head      <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count     <= count_after_pop + CW'(push);
            key_valid <= (count_after_pop + CW'(push)) != '0;
            if (ev_valid && full && !pop)
                overflow <= 1'b1;
            // Head register preloads the next entry; bypass when the FIFO drains to empty.
            if (count_after_pop != '0)
                head <= mem[rd_ptr + PW'(pop)];
            else if (push)
                head <= ev;
        end
    end

    assign key_ascii = head.ascii;
    assign key_code  = head.code;
    assign key_ext   = head.ext;
    assign key_break = head.brk;

endmodule

// File: tb/tb_ps2_key_decoder.sv
module tb_ps2_key_decoder;

    logic       clock = 1'b0;
    logic       reset;
    logic       done;
    logic [7:0] tasta;
    logic       data_valid;
    logic       key_valid;
    logic       key_ready;
    logic [7:0] key_ascii;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       overflow;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    logic [17:0] got_q[$];

    ps2_key_decoder #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .done       (done),
        .tasta      (tasta),
        .data_valid (data_valid),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_ascii  (key_ascii),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_break  (key_break),
        .overflow   (overflow),
        .err_cnt    (err_cnt)
    );

    always #5 clock = ~clock;

    // Record every handshake that will complete on the next rising edge.
    always @(negedge clock)
        if (reset === 1'b0 && key_valid === 1'b1 && key_ready === 1'b1)
            got_q.push_back({key_ascii, key_code, key_ext, key_break});

    function automatic logic [17:0] ev(input logic [7:0] a, input logic [7:0] c,
                                       input logic x, input logic b);
        return {a, c, x, b};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        done  = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);
        got_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic dv);
        tasta      = b;
        data_valid = dv;
        done       = 1'b1;
        tick(6);
        done       = 1'b0;
        tick(4);
    endtask

    task automatic test_reset();
        reset = 1'b1; done = 1'b0; tasta = 8'h00; data_valid = 1'b0; key_ready = 1'b0;
        tick(3);
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid got %h want 0", key_valid); end
        checks++; if (key_ascii !== 8'h00) begin errors++; $display("FAIL reset_key_ascii got %h want 00", key_ascii); end
        checks++; if (key_code !== 8'h00) begin errors++; $display("FAIL reset_key_code got %h want 00", key_code); end
        checks++; if (key_ext !== 1'b0) begin errors++; $display("FAIL reset_key_ext got %h want 0", key_ext); end
        checks++; if (key_break !== 1'b0) begin errors++; $display("FAIL reset_key_break got %h want 0", key_break); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %h want 0", overflow); end
        checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL reset_err_cnt got %h want 00", err_cnt); end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_basic();
        do_reset();
        key_ready = 1'b1;
        send_byte(8'h1C, 1'b1);
        tick(4);
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL basic_count got %0d want 1", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== ev(8'h61, 8'h1C, 1'b0, 1'b0)) begin errors++; $display("FAIL basic_event got %h want %h", got_q[0], ev(8'h61, 8'h1C, 1'b0, 1'b0)); end
        end
    endtask

    // Shift make, letter, shift break, letter again.
    task automatic test_shift_break();
        logic [17:0] exp [5];
        exp[0] = ev(8'h00, 8'h12, 1'b0, 1'b0);
        exp[1] = ev(8'h41, 8'h1C, 1'b0, 1'b0);
        exp[2] = ev(8'h00, 8'h12, 1'b0, 1'b1);
        exp[3] = ev(8'h61, 8'h1C, 1'b0, 1'b0);
        exp[4] = ev(8'h21, 8'h16, 1'b0, 1'b0);
        do_reset();
        key_ready = 1'b1;
        send_byte(8'h12, 1'b1);
        send_byte(8'h1C, 1'b1);
        send_byte(8'hF0, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h1C, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h16, 1'b1);
        tick(4);
        checks++; if (got_q.size() !== 6) begin errors++; $display("FAIL shift_count got %0d want 6", got_q.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (got_q[i] !== exp[i]) begin errors++; $display("FAIL shift_event%0d got %h want %h", i, got_q[i], exp[i]); end
            end
            checks++; if (got_q[5] !== exp[4]) begin errors++; $display("FAIL shift_digit got %h want %h", got_q[5], exp[4]); end
        end
    endtask

    task automatic test_caps();
        do_reset();
        key_ready = 1'b1;
        send_byte(8'h12, 1'b1);
        send_byte(8'h58, 1'b1);
        send_byte(8'h1C, 1'b1);
        tick(4);
        checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL caps_count got %0d want 3", got_q.size()); end
        else begin
            checks++; if (got_q[2] !== ev(8'h61, 8'h1C, 1'b0, 1'b0)) begin errors++; $display("FAIL caps_xor got %h want %h", got_q[2], ev(8'h61, 8'h1C, 1'b0, 1'b0)); end
        end
    endtask

    task automatic test_ext();
        do_reset();
        key_ready = 1'b1;
        send_byte(8'hE0, 1'b1);
        send_byte(8'h75, 1'b1);
        tick(4);
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL ext_count got %0d want 1", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== ev(8'h00, 8'h75, 1'b1, 1'b0)) begin errors++; $display("FAIL ext_event got %h want %h", got_q[0], ev(8'h00, 8'h75, 1'b1, 1'b0)); end
        end
    endtask

    task automatic test_parity();
        do_reset();
        key_ready = 1'b1;
        send_byte(8'h1C, 1'b0);
        tick(4);
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL parity_no_event got %0d want 0", got_q.size()); end
        checks++; if (err_cnt !== 8'h01) begin errors++; $display("FAIL parity_err_cnt got %h want 01", err_cnt); end
        for (int i = 0; i < 255; i++)
            send_byte(8'h1C, 1'b0);
        checks++; if (err_cnt !== 8'hFF) begin errors++; $display("FAIL parity_saturate got %h want FF", err_cnt); end
        // Parity errors must not disturb the prefix FSM.
        send_byte(8'h1C, 1'b1);
        tick(4);
        checks++; if (got_q.size() !== 1 || got_q[0] !== ev(8'h61, 8'h1C, 1'b0, 1'b0)) begin errors++; $display("FAIL parity_after got n=%0d", got_q.size()); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_a [4];
        logic [7:0] exp_c [4];
        exp_a[0] = 8'h61; exp_a[1] = 8'h62; exp_a[2] = 8'h63; exp_a[3] = 8'h64;
        exp_c[0] = 8'h1C; exp_c[1] = 8'h32; exp_c[2] = 8'h21; exp_c[3] = 8'h23;
        do_reset();
        key_ready = 1'b0;
        send_byte(8'h1C, 1'b1);
        send_byte(8'h32, 1'b1);
        send_byte(8'h21, 1'b1);
        send_byte(8'h23, 1'b1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_not_yet got %h want 0", overflow); end
        send_byte(8'h24, 1'b1);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %h want 1", overflow); end
        checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got %h want 1", key_valid); end
        checks++; if (key_ascii !== 8'h61 || key_code !== 8'h1C) begin errors++; $display("FAIL ovf_head got %h/%h want 61/1C", key_ascii, key_code); end
        tick(5);
        checks++; if (key_ascii !== 8'h61 || key_code !== 8'h1C) begin errors++; $display("FAIL ovf_head_stable got %h/%h want 61/1C", key_ascii, key_code); end
        key_ready = 1'b1;
        tick(8);
        checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL drain_count got %0d want 4", got_q.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (got_q[i] !== ev(exp_a[i], exp_c[i], 1'b0, 1'b0)) begin errors++; $display("FAIL drain_event%0d got %h want %h", i, got_q[i], ev(exp_a[i], exp_c[i], 1'b0, 1'b0)); end
            end
        end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %h want 0", key_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %h want 1", overflow); end
    endtask

    task automatic test_reset_mid_prefix();
        do_reset();
        key_ready = 1'b1;
        send_byte(8'hE0, 1'b1);
        do_reset();
        send_byte(8'h1C, 1'b1);
        tick(4);
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL midreset_count got %0d want 1", got_q.size()); end
        else begin
            checks++; if (got_q[0] !== ev(8'h61, 8'h1C, 1'b0, 1'b0)) begin errors++; $display("FAIL midreset_event got %h want %h", got_q[0], ev(8'h61, 8'h1C, 1'b0, 1'b0)); end
        end
    endtask

    // Full FIFO: one pop lands on the same edge as the write of a fifth byte.
    task automatic test_full_pop_write();
        logic [7:0] exp_a [5];
        exp_a[0] = 8'h61; exp_a[1] = 8'h62; exp_a[2] = 8'h63; exp_a[3] = 8'h64; exp_a[4] = 8'h65;
        do_reset();
        key_ready = 1'b0;
        send_byte(8'h1C, 1'b1);
        send_byte(8'h32, 1'b1);
        send_byte(8'h21, 1'b1);
        send_byte(8'h23, 1'b1);
        tasta = 8'h24; data_valid = 1'b1; done = 1'b1;
        tick(4);
        key_ready = 1'b1;
        tick(1);
        key_ready = 1'b0;
        tick(2);
        done = 1'b0;
        tick(6);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simul_no_overflow got %h want 0", overflow); end
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL simul_one_pop got %0d want 1", got_q.size()); end
        key_ready = 1'b1;
        tick(10);
        checks++; if (got_q.size() !== 5) begin errors++; $display("FAIL simul_total got %0d want 5", got_q.size()); end
        else begin
            for (int i = 0; i < 5; i++) begin
                checks++; if (got_q[i][17:10] !== exp_a[i]) begin errors++; $display("FAIL simul_order%0d got %h want %h", i, got_q[i][17:10], exp_a[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_shift_break();
        test_caps();
        test_ext();
        test_parity();
        test_overflow();
        test_reset_mid_prefix();
        test_full_pop_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
